// File: rtl/flag_pkg.sv
// +----------------------------------------------------------------------+
// | flag_pkg : shared NZCV types, forwarding selects and FSM states       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package flag_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] FWD_ARCH  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } flag_state_t;

endpackage

`default_nettype wire

// File: rtl/mux4.sv
// +----------------------------------------------------------------------+
// | mux4 : generic 4-input multiplexer                                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mux4 #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/flag_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | flag_hazard_ctrl : NZCV pipeline, forwarding and B.cond interlock     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module flag_hazard_ctrl
  import flag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             id_uses_flags,
  input  logic             ex_SetFlags,
  input  logic [3:0]       ex_flags,
  input  logic             clr_count,
  output logic [3:0]       cur_flags,
  output logic [1:0]       fwd_sel,
  output logic             flag_stall,
  output logic [3:0]       arch_flags,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  flag_state_t      state_q, state_d;
  logic             ex_mem_sf_q, mem_wb_sf_q;
  nzcv_t            ex_mem_fl_q, mem_wb_fl_q, arch_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    flag_stall = 1'b0;
    case (state_q)
      RUN: begin
        flag_stall = id_uses_flags & ex_SetFlags & ~flush;
        if (flag_stall && !stall_in) state_d = BUBBLE;
      end
      BUBBLE: begin
        // Producer now sits in EX/MEM and is forwarded; no second stall.
        if (!stall_in) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Clearing the perf counter is a software action, so it is honoured
  // even while the pipeline is frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)
      cnt_d = '0;
    else if (flag_stall && !stall_in && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      ex_mem_sf_q <= 1'b0;
      ex_mem_fl_q <= '0;
      mem_wb_sf_q <= 1'b0;
      mem_wb_fl_q <= '0;
      arch_q      <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall_in) begin
        state_q     <= state_d;
        // The bubble is inserted at ID/EX, so the setter in EX still advances.
        ex_mem_sf_q <= ex_SetFlags & ~flush;
        ex_mem_fl_q <= ex_flags;
        mem_wb_sf_q <= ex_mem_sf_q;
        mem_wb_fl_q <= ex_mem_fl_q;
        if (mem_wb_sf_q) arch_q <= mem_wb_fl_q;
      end
    end
  end

  always_comb begin
    if (ex_mem_sf_q)      fwd_sel = FWD_EXMEM;
    else if (mem_wb_sf_q) fwd_sel = FWD_MEMWB;
    else                  fwd_sel = FWD_ARCH;
  end

  mux4 #(.WIDTH(4)) u_flag_mux (
    .sel (fwd_sel),
    .d0  (arch_q),
    .d1  (mem_wb_fl_q),
    .d2  (ex_mem_fl_q),
    .d3  (ex_mem_fl_q),
    .y   (cur_flags)
  );

  assign arch_flags  = arch_q;
  assign stall_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_flag_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_flag_hazard_ctrl : directed self-checking bench, CNT_W=2           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_flag_hazard_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             stall_in, flush, id_uses_flags, ex_SetFlags, clr_count;
  logic [3:0]       ex_flags;
  logic [3:0]       cur_flags, arch_flags;
  logic [1:0]       fwd_sel;
  logic             flag_stall;
  logic [CNT_W-1:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  flag_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_in      (stall_in),
    .flush         (flush),
    .id_uses_flags (id_uses_flags),
    .ex_SetFlags   (ex_SetFlags),
    .ex_flags      (ex_flags),
    .clr_count     (clr_count),
    .cur_flags     (cur_flags),
    .fwd_sel       (fwd_sel),
    .flag_stall    (flag_stall),
    .arch_flags    (arch_flags),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall_in = 1'b0; flush = 1'b0; id_uses_flags = 1'b0;
    ex_SetFlags = 1'b0; ex_flags = 4'b0000; clr_count = 1'b0;
    step(); step();
    chk("rst_cur",   {4'b0, cur_flags},   8'h00);
    chk("rst_fwd",   {6'b0, fwd_sel},     8'h00);
    chk("rst_stall", {7'b0, flag_stall},  8'h00);
    chk("rst_arch",  {4'b0, arch_flags},  8'h00);
    chk("rst_cnt",   {6'b0, stall_count}, 8'h00);
    reset_n = 1'b1;

    // Single setter walks EX/MEM -> MEM/WB -> arch
    ex_SetFlags = 1'b1; ex_flags = 4'b1010;
    step();
    ex_SetFlags = 1'b0; ex_flags = 4'b0000;
    chk("p1_fwd", {6'b0, fwd_sel},   8'b10);
    chk("p1_cur", {4'b0, cur_flags}, 8'b1010);
    step();
    chk("p2_fwd",  {6'b0, fwd_sel},    8'b01);
    chk("p2_cur",  {4'b0, cur_flags},  8'b1010);
    chk("p2_arch", {4'b0, arch_flags}, 8'b0000);
    step();
    chk("p3_arch", {4'b0, arch_flags}, 8'b1010);
    chk("p3_fwd",  {6'b0, fwd_sel},    8'b00);

    // SUBS in EX with a flag reader in ID
    ex_SetFlags = 1'b1; ex_flags = 4'b0110; id_uses_flags = 1'b1;
    #1 chk("h_stall", {7'b0, flag_stall}, 8'h01);
    step();
    ex_SetFlags = 1'b0; ex_flags = 4'b0000;
    #1 chk("h_bub_stall", {7'b0, flag_stall},  8'h00);
    chk("h_cnt",         {6'b0, stall_count}, 8'h01);
    chk("h_fwd",         {6'b0, fwd_sel},     8'b10);
    chk("h_cur",         {4'b0, cur_flags},   8'b0110);
    step();
    id_uses_flags = 1'b0;
    #1 chk("h2_fwd", {6'b0, fwd_sel},   8'b01);
    chk("h2_cur",   {4'b0, cur_flags}, 8'b0110);
    step();
    chk("h3_arch", {4'b0, arch_flags}, 8'b0110);

    // Back-to-back setters
    ex_SetFlags = 1'b1; ex_flags = 4'b0001;
    step();
    ex_flags = 4'b1000;
    step();
    ex_SetFlags = 1'b0; ex_flags = 4'b0000;
    chk("b_fwd", {6'b0, fwd_sel},   8'b10);
    chk("b_cur", {4'b0, cur_flags}, 8'b1000);
    step();
    chk("b2_arch", {4'b0, arch_flags}, 8'b0001);
    chk("b2_cur",  {4'b0, cur_flags},  8'b1000);
    step();
    chk("b3_arch", {4'b0, arch_flags}, 8'b1000);
    chk("b3_fwd",  {6'b0, fwd_sel},    8'b00);

    // Global freeze while in BUBBLE
    ex_SetFlags = 1'b1; ex_flags = 4'b0011; id_uses_flags = 1'b1;
    step();
    stall_in = 1'b1; ex_flags = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("f_stall", {7'b0, flag_stall},  8'h00);
      chk("f_cnt",   {6'b0, stall_count}, 8'h02);
      chk("f_cur",   {4'b0, cur_flags},   8'b0011);
      chk("f_fwd",   {6'b0, fwd_sel},     8'b10);
      chk("f_arch",  {4'b0, arch_flags},  8'b1000);
    end
    stall_in = 1'b0; ex_SetFlags = 1'b0; id_uses_flags = 1'b0;
    step();
    ex_SetFlags = 1'b1; id_uses_flags = 1'b1;
    #1 chk("f_run_stall", {7'b0, flag_stall}, 8'h01);
    ex_SetFlags = 1'b0; id_uses_flags = 1'b0;
    #1 chk("f_rel_cur", {4'b0, cur_flags}, 8'b0011);
    chk("f_rel_fwd",   {6'b0, fwd_sel},   8'b01);
    step();
    chk("f_rel_arch", {4'b0, arch_flags}, 8'b0011);

    // Flush squashes the setter and suppresses the interlock
    flush = 1'b1; ex_SetFlags = 1'b1; ex_flags = 4'b1111; id_uses_flags = 1'b1;
    #1 chk("x_stall", {7'b0, flag_stall}, 8'h00);
    step();
    flush = 1'b0; ex_SetFlags = 1'b0; ex_flags = 4'b0000; id_uses_flags = 1'b0;
    #1 chk("x_fwd", {6'b0, fwd_sel},     8'b00);
    chk("x_cur",   {4'b0, cur_flags},   8'b0011);
    chk("x_cnt",   {6'b0, stall_count}, 8'h02);
    step(); step();
    chk("x_arch", {4'b0, arch_flags}, 8'b0011);

    // Five stall events saturate a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      ex_SetFlags = 1'b1; id_uses_flags = 1'b1;
      step();
      ex_SetFlags = 1'b0; id_uses_flags = 1'b0;
      step();
      chk("s_cnt", {6'b0, stall_count}, 8'h03);
    end

    // Clear beats a simultaneous stall increment
    ex_SetFlags = 1'b1; id_uses_flags = 1'b1; clr_count = 1'b1; ex_flags = 4'b1001;
    step();
    clr_count = 1'b0;
    #1 chk("c_cnt",   {6'b0, stall_count}, 8'h00);
    chk("c_stall",   {7'b0, flag_stall},  8'h00);
    chk("c_cur",     {4'b0, cur_flags},   8'b1001);

    // Asynchronous reset in the middle of BUBBLE
    id_uses_flags = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("r_cur", {4'b0, cur_flags},   8'h00);
    chk("r_fwd",   {6'b0, fwd_sel},     8'h00);
    chk("r_arch",  {4'b0, arch_flags},  8'h00);
    chk("r_cnt",   {6'b0, stall_count}, 8'h00);
    chk("r_stall", {7'b0, flag_stall},  8'h00);
    id_uses_flags = 1'b1;
    #1 chk("r_run", {7'b0, flag_stall}, 8'h01);
    ex_SetFlags = 1'b0; id_uses_flags = 1'b0;
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
